// File: rtl/up_sampler_pkg.sv
// Shared types and sizing helpers for the 2x up-sampler.
package up_sampler_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    localparam int unsigned DW_DEF = 8;

    // Counter width able to hold every value 0..range.
    function automatic int unsigned cnt_w(input int unsigned range);
        return $clog2(range) + 1;
    endfunction

endpackage

// File: rtl/up_line_buf.sv
// Single-line buffer: simple dual-port RAM with a synchronous read port.
module up_line_buf #(
    parameter int unsigned DEPTH = 400,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write on accepted input pixel; registered read on replay issue.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/up_sampler.sv
// 2x pixel/line replicating up-sampler fed from a read-enable/valid FIFO.
// Optional sof/eol markers are built when UPSAMPLE_MARKERS_EN is defined.
module up_sampler
    import up_sampler_pkg::*;
#(
    parameter int unsigned IN_W = 400,
    parameter int unsigned IN_H = 300,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    output logic          rd_en,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout,
    output logic          sof,
    output logic          eol,
    output logic          frame_done
);

    localparam int unsigned BEATS = 2 * IN_W;
    localparam int unsigned ICW   = cnt_w(IN_W);
    localparam int unsigned OCW   = cnt_w(BEATS);
    localparam int unsigned LCW   = cnt_w(IN_H);
    localparam int unsigned AW    = (IN_W > 1) ? $clog2(IN_W) : 1;

    state_t         state_q, state_d;
    logic [ICW-1:0] in_col;
    logic [OCW-1:0] out_col;
    logic [OCW-1:0] rep_col;
    logic [LCW-1:0] line;
    logic           inflight;
    logic           hold_v;
    logic           hold_ph;
    logic           src_buf;
    logic [DW-1:0]  hold_px;
    logic [DW-1:0]  buf_q;
    logic           fd_q;

    logic accept_c, last_beat_c, load_c, rd_en_c, issue_c;

    assign accept_c    = hold_v & dout_ready;
    assign last_beat_c = accept_c & (out_col == OCW'(BEATS - 1));
    assign load_c      = (state_q == FILL) & inflight & din_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Next state plus FIFO request / buffer replay issue.
    always_comb begin
        state_d = state_q;
        rd_en_c = 1'b0;
        issue_c = 1'b0;
        case (state_q)
            FILL: begin
                rd_en_c = !rst & (in_col < ICW'(IN_W)) & !inflight
                        & (!hold_v | (hold_ph & dout_ready));
                if (last_beat_c) state_d = REPLAY;
            end
            REPLAY: begin
                issue_c = (rep_col < OCW'(BEATS)) & (!hold_v | dout_ready);
                if (last_beat_c) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Hold register, counters and frame-done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col   <= '0;
            out_col  <= '0;
            rep_col  <= '0;
            line     <= '0;
            inflight <= 1'b0;
            hold_v   <= 1'b0;
            hold_ph  <= 1'b0;
            src_buf  <= 1'b0;
            hold_px  <= '0;
            fd_q     <= 1'b0;
        end else begin
            inflight <= rd_en_c;
            fd_q     <= 1'b0;
            if (load_c) begin
                hold_px <= din;
                hold_v  <= 1'b1;
                hold_ph <= 1'b0;
                src_buf <= 1'b0;
                in_col  <= in_col + ICW'(1);
            end else if (issue_c) begin
                hold_v  <= 1'b1;
                hold_ph <= rep_col[0];
                src_buf <= 1'b1;
                rep_col <= rep_col + OCW'(1);
            end else if (accept_c) begin
                if (state_q == FILL && !hold_ph) hold_ph <= 1'b1;
                else                             hold_v  <= 1'b0;
            end
            if (accept_c) out_col <= last_beat_c ? '0 : out_col + OCW'(1);
            if (last_beat_c && state_q == FILL) in_col <= '0;
            if (last_beat_c && state_q == REPLAY) begin
                rep_col <= '0;
                if (line == LCW'(IN_H - 1)) begin
                    line <= '0;
                    fd_q <= 1'b1;
                end else begin
                    line <= line + LCW'(1);
                end
            end
        end
    end

    up_line_buf #(
        .DEPTH(IN_W),
        .DW   (DW),
        .AW   (AW)
    ) u_line_buf (
        .clk  (clk),
        .we   (load_c),
        .waddr(AW'(in_col)),
        .wdata(din),
        .re   (issue_c),
        .raddr(AW'(rep_col[OCW-1:1])),
        .rdata(buf_q)
    );

`ifdef UPSAMPLE_MARKERS_EN
    logic sof_q, eol_q;

    // Markers follow each new beat and hold with it under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sof_q <= 1'b0;
            eol_q <= 1'b0;
        end else if (load_c) begin
            sof_q <= (line == '0) && (out_col == '0);
            eol_q <= 1'b0;
        end else if (issue_c) begin
            sof_q <= 1'b0;
            eol_q <= (rep_col == OCW'(BEATS - 1));
        end else if (accept_c && state_q == FILL && !hold_ph) begin
            sof_q <= 1'b0;
            eol_q <= (out_col == OCW'(BEATS - 2));
        end
    end

    assign sof = sof_q;
    assign eol = eol_q;
`else
    assign sof = 1'b0;
    assign eol = 1'b0;
`endif

    assign rd_en      = rd_en_c;
    assign dout_valid = hold_v;
    assign dout       = src_buf ? buf_q : hold_px;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_up_sampler.sv
// Self-checking bench for up_sampler with IN_W=4, IN_H=2.
module tb_up_sampler;

    localparam int unsigned IN_W = 4;
    localparam int unsigned IN_H = 2;
    localparam int unsigned DW   = 8;
    localparam int FRAME_BEATS   = 4 * IN_W * IN_H;
`ifdef UPSAMPLE_MARKERS_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          dout_ready = 1'b0;
    logic          rd_en, dout_valid, sof, eol, frame_done;
    logic [DW-1:0] dout;

    up_sampler #(.IN_W(IN_W), .IN_H(IN_H), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .din_valid (din_valid),
        .din       (din),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout      (dout),
        .sof       (sof),
        .eol       (eol),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] px;
        logic       sof;
        logic       eol;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fifo_q[$];
    int         fd_at[$];
    int         tests = 0;
    int         fails = 0;

    bit         req_prev = 1'b0, rst_edge, exp_fd = 1'b0, prev_hold = 1'b0;
    logic [7:0] prev_dout;
    logic       prev_sof, prev_eol;
    int         frame_beats = 0, beats_total = 0, pops = 0;
    int         empty_left = 0, stall_left = 0, stall_px = -1, stall_hits = 0;
    bit         stall_arm = 1'b0, rdy_rand = 1'b0, empty_rand = 1'b0, in_stall;
    logic [7:0] cap[32];
    int         cap_n = 0;
    int         lit[32] = '{1,1,2,2,3,3,4,4, 1,1,2,2,3,3,4,4,
                            5,5,6,6,7,7,8,8, 5,5,6,6,7,7,8,8};

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: each source pixel twice per line, each line twice per frame.
    task automatic push_frame(input int base, input bit rnd);
        logic [7:0] px[IN_H][IN_W];
        beat_t b;
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++) begin
                px[r][c] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + r * IN_W + c);
                fifo_q.push_back(px[r][c]);
            end
        for (int r = 0; r < IN_H; r++)
            for (int rep = 0; rep < 2; rep++)
                for (int c = 0; c < IN_W; c++)
                    for (int ph = 0; ph < 2; ph++) begin
                        b.px  = px[r][c];
                        b.sof = MARK && r == 0 && rep == 0 && c == 0 && ph == 0;
                        b.eol = MARK && c == IN_W - 1 && ph == 1;
                        exp_q.push_back(b);
                    end
    endtask

    // One clock: drive FIFO/ready after the edge, check outputs on the falling edge.
    task automatic cycle();
        bit    acc, dry;
        beat_t e;
        @(posedge clk);
        rst_edge = rst;
        #1;
        if (stall_arm && dout_valid && frame_beats == 5) begin
            stall_arm  = 1'b0;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            dout_ready = 1'b0;
            stall_left--;
            in_stall = 1'b1;
        end else begin
            dout_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_stall = 1'b0;
        end
        dry = (empty_left > 0) || (empty_rand && $urandom_range(0, 3) == 0);
        if (empty_left > 0) empty_left--;
        if (!rst_edge && req_prev && !dry && fifo_q.size() > 0) begin
            din_valid = 1'b1;
            din = fifo_q.pop_front();
            pops++;
        end else begin
            din_valid = 1'b0;
            din = 8'($urandom);
        end
        @(negedge clk);
        exp_fd_check: begin
            if (rst_edge) begin
                chk("reset_rd_en", rd_en, 0);
                chk("reset_dout_valid", dout_valid, 0);
                chk("reset_dout", dout, 0);
                chk("reset_sof", sof, 0);
                chk("reset_eol", eol, 0);
                chk("reset_frame_done", frame_done, 0);
                exp_fd = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", dout_valid, 1);
                    chk("hold_dout", dout, prev_dout);
                    chk("hold_sof", sof, prev_sof);
                    chk("hold_eol", eol, prev_eol);
                end
                if (in_stall && stall_px >= 0) begin
                    chk("stall_px", dout, stall_px);
                    if (dout_valid) stall_hits++;
                end
                if (dout_valid && !dout_ready) chk("rd_en_in_stall", rd_en, 0);
                chk("frame_done", frame_done, exp_fd);
                if (frame_done) fd_at.push_back(beats_total - 1);
                exp_fd = 1'b0;
                acc = dout_valid && dout_ready;
                if (acc) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_beat: got dout %0d, required no beat", dout);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_dout", dout, e.px);
                        chk("beat_sof", sof, e.sof);
                        chk("beat_eol", eol, e.eol);
                    end
                    if (cap_n < 32) begin
                        cap[cap_n] = dout;
                        cap_n++;
                    end
                    beats_total++;
                    frame_beats++;
                    if (frame_beats == FRAME_BEATS) begin
                        frame_beats = 0;
                        exp_fd = 1'b1;
                    end
                end
            end
        end
        prev_hold = !rst_edge && dout_valid && !dout_ready;
        prev_dout = dout;
        prev_sof  = sof;
        prev_eol  = eol;
        req_prev  = rd_en;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        cycle();
        cycle();
    endtask

    initial begin
        int n;
        // Reset, then two back-to-back frames with free-running FIFO and sink.
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        push_frame(1, 1'b0);
        push_frame(9, 1'b0);
        drain(400);
        for (int i = 0; i < 32; i++) chk("first_frame_literal", cap[i], lit[i]);
        chk("fd_count_b2b", fd_at.size(), 2);
        chk("fd_beat_first", fd_at.size() > 0 ? fd_at[0] : -1, 31);
        chk("fd_beat_second", fd_at.size() > 1 ? fd_at[1] : -1, 63);

        // FIFO empty after pixel 2 and a 5-cycle stall on phase 1 of pixel 3.
        fd_at.delete();
        pops = 0;
        push_frame(1, 1'b0);
        stall_arm = 1'b1;
        stall_px  = 3;
        n = 0;
        while (pops < 2 && n < 200) begin
            cycle();
            n++;
        end
        empty_left = 3;
        drain(400);
        stall_px = -1;
        chk("stall_cycles_seen", stall_hits, 5);
        chk("fd_count_gap", fd_at.size(), 1);

        // Reset in the middle of the first replayed line, then a clean frame.
        fd_at.delete();
        push_frame(17, 1'b0);
        n = 0;
        while (frame_beats < 10 && n < 200) begin
            cycle();
            n++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        frame_beats = 0;
        push_frame(9, 1'b0);
        drain(400);
        chk("fd_count_after_reset", fd_at.size(), 1);

        // Random pixels, random FIFO gaps and random back-pressure.
        fd_at.delete();
        rdy_rand   = 1'b1;
        empty_rand = 1'b1;
        repeat (3) push_frame(0, 1'b1);
        drain(3000);
        chk("fd_count_random", fd_at.size(), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

endmodule
